single_cycle_mips_cpu: RTL and testbench

- Single-cycle 32-bit MIPS core: fetch, decode, execute, memory access and writeback all complete in one clk period.
- Contains a word-addressed instruction ROM, a 32x32 register file and a word-addressed data RAM.
- Exposes PC, the current instruction and four decoded control strobes for debug and waveform observation.
- Instruction memory is loaded externally by hierarchical file load before reset is released.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mips_alu.sv | 24 ++
 rtl/mips_mem.sv | 57 +++++
 rtl/single_cycle_mips_cpu.sv | 106 ++++++++++
 tb/tb_single_cycle_mips_cpu.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU control codes and index-width helper
// for the single-cycle MIPS core.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU: and/or/add/sub/signed slt; zero flags an all-zero result.
import mips_pkg::*;

module mips_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/mips_mem.sv
// Storage blocks: 32x32 register file, instruction ROM, data RAM.
// Power-on contents are zero; the ROM is filled externally before use.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regFile [0:31] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regFile[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regFile[ra2];
endmodule

module mips_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:DEPTH-1] = '{default: '0};

  assign rdata = memory[addr];
endmodule

module mips_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:DEPTH-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

// File: rtl/single_cycle_mips_cpu.sv
// Single-cycle MIPS core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// Define MIPS_BNE_EN to also decode bne.
import mips_pkg::*;

module single_cycle_mips_cpu #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        Jump
);
  localparam int IAW = idx_w(IMEM_DEPTH);
  localparam int DAW = idx_w(DMEM_DEPTH);

  logic [31:0] pc_r = '0;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, rd1, rd2, alu_b, alu_res, dm_rdata, wd, pc4, pc_next;
  logic [2:0]  alu_ctrl;
  logic        mem_write, mem_to_reg, reg_dst, is_bne, zero, taken;
  logic        unused_shamt;

  assign pc     = pc_r;
  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign imm    = {{16{instruction[15]}}, instruction[15:0]};
  assign unused_shamt = ^instruction[10:6];

  mips_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) inst_mem (
    .addr(pc_r[IAW+1:2]), .rdata(instruction)
  );

  // Anything not explicitly decoded leaves every strobe low, i.e. a NOP.
  always_comb begin
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    is_bne     = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          F_ADD:   begin RegWrite = 1'b1; alu_ctrl = ALU_ADD; end
          F_SUB:   begin RegWrite = 1'b1; alu_ctrl = ALU_SUB; end
          F_AND:   begin RegWrite = 1'b1; alu_ctrl = ALU_AND; end
          F_OR:    begin RegWrite = 1'b1; alu_ctrl = ALU_OR;  end
          F_SLT:   begin RegWrite = 1'b1; alu_ctrl = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
      OP_LW:   begin RegWrite = 1'b1; ALUSrc = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin ALUSrc = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  begin Branch = 1'b1; alu_ctrl = ALU_SUB; end
`ifdef MIPS_BNE_EN
      OP_BNE:  begin Branch = 1'b1; is_bne = 1'b1; alu_ctrl = ALU_SUB; end
`endif
      OP_J:    Jump = 1'b1;
      default: ;
    endcase
  end

  mips_regfile reg_file (
    .clk(clk), .rst(rst), .we(RegWrite && !rst),
    .ra1(rs), .ra2(rt), .wa(reg_dst ? rd : rt), .wd(wd),
    .rd1(rd1), .rd2(rd2)
  );

  assign alu_b = ALUSrc ? imm : rd2;

  mips_alu alu (.a(rd1), .b(alu_b), .alu_ctrl(alu_ctrl), .result(alu_res), .zero(zero));

  mips_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) data_mem (
    .clk(clk), .we(mem_write && !rst), .addr(alu_res[DAW+1:2]),
    .wdata(rd2), .rdata(dm_rdata)
  );

  assign wd    = mem_to_reg ? dm_rdata : alu_res;
  assign taken = Branch && (is_bne ? !zero : zero);
  assign pc4   = pc_r + 32'd4;

  always_comb begin
    pc_next = pc4;
    if (Jump)       pc_next = {pc4[31:28], instruction[25:0], 2'b00};
    else if (taken) pc_next = pc4 + {imm[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) pc_r <= '0;
    else     pc_r <= pc_next;
  end
endmodule

// File: tb/tb_single_cycle_mips_cpu.sv
// Directed-vector bench for single_cycle_mips_cpu: small programs are
// poked into the instruction ROM and architectural state is checked.
module tb_single_cycle_mips_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, instruction;
  logic        RegWrite, ALUSrc, Branch, Jump;
  int          n_chk = 0;
  int          n_err = 0;

  single_cycle_mips_cpu dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 256; i++) dut.inst_mem.memory[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
  endtask

  task automatic chk_regs_zero(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | dut.reg_file.regFile[i];
    chk(tag, acc, 32'h0);
  endtask

  initial begin
    // Power-on and reset / sequential fetch over NOPs
    clr_imem();
    #1;
    chk("poweron_pc", pc, 32'h0);
    step();
    chk("reset_pc", pc, 32'h0);
    chk_regs_zero("reset_regs");
    rst = 1'b0;
    chk("nop_ctrl", {28'h0, RegWrite, ALUSrc, Branch, Jump}, 32'h0);
    step(); chk("seq_pc4", pc, 32'h4);
    step(); chk("seq_pc8", pc, 32'h8);
    step(); chk("seq_pc12", pc, 32'hC);

    // ALU ops
    clr_imem();
    dut.inst_mem.memory[0] = 32'h20010005; // addi $1,$0,5
    dut.inst_mem.memory[1] = 32'h2002FFFD; // addi $2,$0,-3
    dut.inst_mem.memory[2] = 32'h00221820; // add  $3,$1,$2
    dut.inst_mem.memory[3] = 32'h00222022; // sub  $4,$1,$2
    dut.inst_mem.memory[4] = 32'h0041282A; // slt  $5,$2,$1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("alu_regwrite%0d", i), {31'h0, RegWrite}, 32'h1);
      chk($sformatf("alu_alusrc%0d", i), {31'h0, ALUSrc}, (i < 2) ? 32'h1 : 32'h0);
      step();
    end
    chk("r1", dut.reg_file.regFile[1], 32'h5);
    chk("r2", dut.reg_file.regFile[2], 32'hFFFFFFFD);
    chk("add_r3", dut.reg_file.regFile[3], 32'h2);
    chk("sub_r4", dut.reg_file.regFile[4], 32'h8);
    chk("slt_r5", dut.reg_file.regFile[5], 32'h1);

    // Memory store / load
    clr_imem();
    dut.inst_mem.memory[0] = 32'h20010077; // addi $1,$0,0x77
    dut.inst_mem.memory[1] = 32'hAC010008; // sw   $1,8($0)
    dut.inst_mem.memory[2] = 32'h8C060008; // lw   $6,8($0)
    do_reset();
    step();
    chk("sw_regwrite", {31'h0, RegWrite}, 32'h0);
    chk("sw_alusrc", {31'h0, ALUSrc}, 32'h1);
    step();
    chk("sw_dmem2", dut.data_mem.memory[2], 32'h77);
    step();
    chk("lw_r6", dut.reg_file.regFile[6], 32'h77);

    // Mid-run reset at pc 0x14
    step(); step();
    chk("midrun_pc_before", pc, 32'h14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_pc", pc, 32'h0);
    chk_regs_zero("midrun_regs");
    chk("midrun_dmem_kept", dut.data_mem.memory[2], 32'h77);

    // Branch, jump, $0 write, unsupported funct, opcode 0x05
    clr_imem();
    dut.inst_mem.memory[0]  = 32'h20010001; // addi $1,$0,1
    dut.inst_mem.memory[4]  = 32'h10000002; // 0x10 beq $0,$0,+2
    dut.inst_mem.memory[7]  = 32'h10200005; // 0x1C beq $1,$0,+5
    dut.inst_mem.memory[8]  = 32'h08000040; // 0x20 j 0x40
    dut.inst_mem.memory[64] = 32'h20000009; // 0x100 addi $0,$0,9
    dut.inst_mem.memory[65] = 32'h00213821; // 0x104 funct 0x21
    dut.inst_mem.memory[66] = 32'h14200003; // 0x108 bne $1,$0,+3
    do_reset();
    step(); step(); step(); step();
    chk("beq_at_pc", pc, 32'h10);
    chk("beq_branch", {31'h0, Branch}, 32'h1);
    chk("beq_jump", {31'h0, Jump}, 32'h0);
    step();
    chk("beq_taken_pc", pc, 32'h1C);
    chk("beq2_branch", {31'h0, Branch}, 32'h1);
    step();
    chk("beq_not_taken_pc", pc, 32'h20);
    chk("j_jump", {31'h0, Jump}, 32'h1);
    chk("j_regwrite", {31'h0, RegWrite}, 32'h0);
    step();
    chk("j_pc", pc, 32'h100);
    chk("r0w_regwrite", {31'h0, RegWrite}, 32'h1);
    step();
    chk("r0_zero", dut.reg_file.regFile[0], 32'h0);
    chk("badfunct_pc", pc, 32'h104);
    chk("badfunct_ctrl", {28'h0, RegWrite, ALUSrc, Branch, Jump}, 32'h0);
    step();
    chk("badfunct_r7", dut.reg_file.regFile[7], 32'h0);
    chk("op05_pc", pc, 32'h108);
`ifdef MIPS_BNE_EN
    chk("bne_branch", {31'h0, Branch}, 32'h1);
    step();
    chk("bne_taken_pc", pc, 32'h118);
`else
    chk("op05_branch", {31'h0, Branch}, 32'h0);
    step();
    chk("op05_nop_pc", pc, 32'h10C);
`endif

    // Reset holds pc while control still follows the fetched word
    rst = 1'b1;
    step();
    chk("rst_hold_pc", pc, 32'h0);
    chk("rst_ctrl_follows", {31'h0, ALUSrc}, 32'h1);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
